pr_operand_feeder: RTL
======================

Name: pr_operand_feeder

Overview:
- Transmitter end of the RCA operand valid/ack interface that feeds a PR unit's data input port (data_in / data_valid_in / data_in_ack).
- Buffers operand words pushed from the issue side in a small FIFO.
- Presents the head word with a valid flag and pops it when the PR unit acks.
- One instance sits in front of each PR unit input port.

Parameters:
- DEPTH, 4, number of XLEN-bit entries; must be a power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all buffered operands
- wr_data  in  XLEN  operand word from issue side
- wr_en  in  1  push request
- full  out  1  count == DEPTH
- count  out  CNT_W  current occupancy
- overflow  out  1  sticky: a push was dropped
- data_out  out  XLEN  head operand to PR unit
- data_valid_out  out  1  head operand valid
- data_ack_in  in  1  PR unit consumed the head word this cycle

Behaviour:
- Reset (rst low, async): rd_ptr=0, wr_ptr=0, count=0, overflow=0, data_valid_out=0, data_out=0. Storage array is not reset.
- Pop condition:
  - pop = data_valid_out && data_ack_in, evaluated at the rising edge.
  - data_ack_in while data_valid_out=0 is ignored.
  - The PR unit may ack in the same cycle that valid rises; acks are combinational on its side, so the feeder must not gate its ack sampling.
- Push condition:
  - push = wr_en && (!full || pop).
  - A push into a full FIFO is accepted in a cycle where the head is popped.
- Drop: wr_en && full && !pop drops the word and sets overflow=1. Storage, pointers and count are unchanged.
- Simultaneous push+pop: count unchanged; both pointers advance.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH, from DEPTH-1 to 0.
- Count: +1 on push only, -1 on pop only; range 0..DEPTH.
- Output timing (no bypass):
  - data_valid_out = (count != 0), registered.
  - data_out = mem[rd_ptr] when valid, else 0.
  - Write-to-valid latency is 1 cycle: a word pushed at edge N is presented from cycle N+1.
- Head stability: while data_valid_out=1 and no pop, data_out holds its value regardless of pushes.
- Flush:
  - Priority over push and pop.
  - Next edge: count=0, pointers=0, overflow=0, data_valid_out=0.
  - A wr_en in the flush cycle is discarded without setting overflow.
  - data_ack_in in the flush cycle is ignored.
- Reset mid-transfer: all buffered words are lost. data_valid_out falls asynchronously with rst.
- No state machine beyond the FIFO. The state is fully defined by count, pointers and overflow.

Optional Feature:
- Macro: PR_FEEDER_BYPASS_EN.
- Defined (bypass path when count==0):
  - When wr_en=1, data_out=wr_data and data_valid_out=1 combinationally in the same cycle.
  - If data_ack_in=1 that cycle, the word is consumed and not stored; count stays 0.
  - If not acked, the word is stored as a normal push and presented from storage the next cycle with the same value.
  - Flush suppresses the bypass valid.
- Undefined: no bypass. Behaviour is exactly the 1-cycle latency path above.

Test Plan:
- Reset then single push of 0xDEADBEEF, ack held low: valid=0 in the push cycle, valid=1 and data_out=0xDEADBEEF from the next cycle and held for 5 cycles. Ack for 1 cycle gives valid=0 and count=0 the following cycle.
- Push 0x1,0x2,0x3,0x4 back-to-back (DEPTH=4), no ack: full=1, count=4. 5th push of 0x5 is dropped and overflow=1. Acking 4 times yields 0x1,0x2,0x3,0x4 in order.
- Full FIFO with push 0x9 and ack in the same cycle: push accepted, count stays 4, overflow stays 0. Subsequent drain order is 0x2,0x3,0x4,0x9.
- Wrap-around: 10 push/pop pairs with values 0x10..0x19 at 1 per cycle, ack held high: output sequence is 0x10..0x19, count never exceeds 1, pointers wrap twice.
- Flush with count=3 and simultaneous wr_en=1 (0xAA) and ack=1: next cycle count=0, valid=0, overflow=0, and 0xAA is never presented.
- Bypass (PR_FEEDER_BYPASS_EN defined): on an empty FIFO, wr_en=1 with 0x55 and ack=1 in the same cycle gives data_out=0x55 and valid=1 that cycle, and count=0 next cycle. With the macro undefined the same stimulus gives valid=0 in the push cycle and 0x55 presented the next cycle.

Source files
------------

// File: rtl/pr_operand_feeder.sv
// Operand FIFO feeding a PR unit data input port over a valid/ack handshake.
// Optional macro PR_FEEDER_BYPASS_EN adds a same-cycle bypass path when the FIFO is empty.
module pr_operand_feeder #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic [XLEN-1:0]  data_out,
    output logic             data_valid_out,
    input  logic             data_ack_in
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_valid;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_bypass_valid;
    logic             w_bypass_take;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_full = (r_count == CNT_W'(DEPTH));

    // Ack is sampled ungated; it only counts when a stored head is being presented.
    assign w_pop = r_valid && data_ack_in && !flush;

`ifdef PR_FEEDER_BYPASS_EN
    assign w_bypass_valid = (r_count == '0) && wr_en && !flush;
    assign w_bypass_take  = w_bypass_valid && data_ack_in;
`else
    assign w_bypass_valid = 1'b0;
    assign w_bypass_take  = 1'b0;
`endif

    assign w_push = wr_en && !flush && (!w_full || w_pop) && !w_bypass_take;
    assign w_drop = wr_en && !flush && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (flush)
            w_count_nxt = '0;
        else if (w_push && !w_pop)
            w_count_nxt = r_count + CNT_W'(1);
        else if (w_pop && !w_push)
            w_count_nxt = r_count - CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else if (flush) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_drop)
                r_overflow <= 1'b1;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    // NOTE: storage has no reset; contents are only observable through r_valid, which is reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wr_data;
    end

    assign full           = w_full;
    assign count          = r_count;
    assign overflow       = r_overflow;
    assign data_valid_out = r_valid || w_bypass_valid;

    // NOTE: every path of this mux assigns data_out, so no latch is inferred.
    always_comb begin
        if (w_bypass_valid)
            data_out = wr_data;
        else if (r_valid)
            data_out = r_mem[r_rd_ptr];
        else
            data_out = '0;
    end

endmodule
